// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// operation encodings and the controller state type.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's complement: y = neg ? (~x + cin) : x.
// The carry-in lets two W-bit halves of a 2W-bit value be negated together.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  input  logic         cin_i,
  output logic [W-1:0] y_o
);

  assign y_o = (neg_i ? ~x_i : x_i) + {{(W-1){1'b0}}, neg_i & cin_i};

endmodule

// File: rtl/mult_div_seq.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one radix-2 step per cycle,
// sign handled by magnitude conversion in PREP and correction in FIX.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             is_div, is_signed, in_fix;
  logic [WIDTH-1:0] conv_lo, conv_hi, conv_hi_x;
  logic             conv_lo_neg, conv_hi_neg, conv_hi_cin;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign in_fix    = (state_q == FIX);

  // PREP: low_q/opb_q hold raw a/b and are converted to magnitudes.
  // FIX: low_q/acc_q hold the unsigned result and are sign-corrected.
  assign conv_lo_neg = in_fix ? res_neg_q : (is_signed & low_q[WIDTH-1]);
  assign conv_hi_x   = in_fix ? acc_q : opb_q;
  assign conv_hi_neg = in_fix ? (is_div ? rem_neg_q : res_neg_q)
                              : (is_signed & opb_q[WIDTH-1]);
  assign conv_hi_cin = (in_fix && !is_div) ? (low_q == '0) : 1'b1;

  mdu_abs_neg #(.W(WIDTH)) u_conv_lo (
    .x_i   (low_q),
    .neg_i (conv_lo_neg),
    .cin_i (1'b1),
    .y_o   (conv_lo)
  );

  mdu_abs_neg #(.W(WIDTH)) u_conv_hi (
    .x_i   (conv_hi_x),
    .neg_i (conv_hi_neg),
    .cin_i (conv_hi_cin),
    .y_o   (conv_hi)
  );

  assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opb_q});
  // The true difference is below the divisor, so it always fits in WIDTH bits.
  assign div_rem   = div_shift[WIDTH-1:0] - opb_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hi_wen) hi_d = wdata;
        if (lo_wen) lo_d = wdata;
        if (start) begin
          op_d    = op;
          low_d   = a;
          opb_d   = b;
          state_d = PREP;
        end
      end
      PREP: begin
        if (is_div && (opb_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end else begin
          low_d     = conv_lo;
          opb_d     = conv_hi;
          acc_d     = '0;
          cnt_d     = '0;
          res_neg_d = is_signed & (low_q[WIDTH-1] ^ opb_q[WIDTH-1]);
          rem_neg_d = is_signed & low_q[WIDTH-1];
          state_d   = RUN;
        end
      end
      RUN: begin
        if (is_div) begin
          acc_d = div_ok ? div_rem : div_shift[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        lo_d    = conv_lo;
        hi_d    = conv_hi;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
